// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// trace_pkg : shared types and constants for the trace_uart_dump capture path
// Rev 1.0   : initial release
// ============================================================================
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DUMP    = 2'd3
  } state_t;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int nb_bytes(input int width);
    return (width + 7) / 8;
  endfunction

  // MSB-first CRC-8, no reflection
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// uart_tx_byte : 8N1 transmitter, LSB first, one byte per tx_valid/tx_ready handshake
// Rev 1.0      : initial release
// ============================================================================
module uart_tx_byte #(
  parameter int BIT_CYC = 234
) (
  input  logic       clk_27,
  input  logic       rst,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_o
);

  localparam int            CW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);

  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bits_q, bits_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tx_ready_o = (bits_q == 4'd0);
  // The line is driven straight from the shift register, filled with ones when idle.
  assign tx_o       = shift_q[0];

  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    if (tx_ready_o) begin
      if (tx_valid_i) begin
        shift_d = {1'b1, tx_data_i, 1'b0};
        bits_d  = 4'd10;
        cnt_d   = BIT_LAST;
      end
    end else if (cnt_q == '0) begin
      shift_d = {1'b1, shift_q[9:1]};
      bits_d  = bits_q - 4'd1;
      cnt_d   = BIT_LAST;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_27 or posedge rst) begin
    if (rst) begin
      shift_q <= '1;
      bits_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_uart_dump.sv
`default_nettype none
// ============================================================================
// trace_uart_dump : trigger-started probe capture into BRAM, dumped over UART.
//                   Define TRACE_CRC8_EN to append a CRC-8 over the sample bytes.
// Rev 1.0         : initial release (requires DEPTH >= 2)
// ============================================================================
module trace_uart_dump
  import trace_pkg::*;
#(
  parameter int PROBE_W = 54,
  parameter int DEPTH   = 256,
  parameter int CLK_HZ  = 27_000_000,
  parameter int BAUD    = 115_200
) (
  input  logic               clk_27,
  input  logic               rst,
  input  logic [PROBE_W-1:0] probe_i,
  input  logic               sample_en_i,
  input  logic               arm_i,
  input  logic               trig_i,
  output logic               uart_tx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int            NB        = nb_bytes(PROBE_W);
  localparam int            AW        = $clog2(DEPTH);
  localparam int            SW        = (NB > 1) ? $clog2(NB) : 1;
  localparam int            BIT_CYC   = CLK_HZ / BAUD;
  localparam logic [SW-1:0] LAST_SEL  = SW'(NB - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  state_t             state_q, state_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]      byte_sel_q, byte_sel_d;
  logic               hdr_phase_q, hdr_phase_d;
  logic               last_sent_q, last_sent_d;
  logic [PROBE_W-1:0] cur_word_q, cur_word_d;
  logic [PROBE_W-1:0] rd_data_q;
  logic [PROBE_W-1:0] mem [DEPTH];
  logic [NB*8-1:0]    word_pad;
  logic               wr_en, tx_valid, tx_ready;
  logic [7:0]         tx_byte;
`ifdef TRACE_CRC8_EN
  logic [7:0]         crc_q, crc_d;
  logic               crc_phase_q, crc_phase_d;
`endif

  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    byte_sel_d  = byte_sel_q;
    hdr_phase_d = hdr_phase_q;
    last_sent_d = last_sent_q;
    cur_word_d  = cur_word_q;
    wr_en       = 1'b0;
    done_o      = 1'b0;
    tx_valid    = (state_q == ST_DUMP) && !last_sent_q;
`ifdef TRACE_CRC8_EN
    crc_d       = crc_q;
    crc_phase_d = crc_phase_q;
`endif

    // Byte 0 of a sample comes straight from the BRAM output; later bytes from the latched copy.
    word_pad = '0;
    word_pad[PROBE_W-1:0] = (byte_sel_q == '0) ? rd_data_q : cur_word_q;
    tx_byte = word_pad[{byte_sel_q, 3'b000} +: 8];
    if (hdr_phase_q) tx_byte = HDR_BYTE;
`ifdef TRACE_CRC8_EN
    if (crc_phase_q) tx_byte = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        wr_ptr_d = '0;
        if (arm_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_i) begin
          wr_en   = sample_en_i;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: wr_en = sample_en_i;
      ST_DUMP: begin
        if (last_sent_q) begin
          if (tx_ready) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tx_ready) begin
          if (hdr_phase_q) begin
            hdr_phase_d = 1'b0;
          end
`ifdef TRACE_CRC8_EN
          else if (crc_phase_q) begin
            crc_phase_d = 1'b0;
            last_sent_d = 1'b1;
          end
`endif
          else begin
`ifdef TRACE_CRC8_EN
            crc_d = crc8_update(crc_q, tx_byte);
`endif
            if (byte_sel_q == '0) begin
              cur_word_d = rd_data_q;
              rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end
            if (byte_sel_q == LAST_SEL) begin
              byte_sel_d = '0;
              if (rd_ptr_d == DEPTH_CNT) begin
`ifdef TRACE_CRC8_EN
                crc_phase_d = 1'b1;
`else
                last_sent_d = 1'b1;
`endif
              end
            end else begin
              byte_sel_d = byte_sel_q + SW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // The extra pointer bit marks a full buffer; capture stops there so nothing is overwritten.
    if (((state_q == ST_ARMED) || (state_q == ST_CAPTURE)) && wr_ptr_d[AW]) begin
      state_d     = ST_DUMP;
      rd_ptr_d    = '0;
      byte_sel_d  = '0;
      hdr_phase_d = 1'b1;
      last_sent_d = 1'b0;
`ifdef TRACE_CRC8_EN
      crc_d       = 8'h00;
      crc_phase_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_27 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_sel_q  <= '0;
      hdr_phase_q <= 1'b0;
      last_sent_q <= 1'b0;
      cur_word_q  <= '0;
`ifdef TRACE_CRC8_EN
      crc_q       <= 8'h00;
      crc_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_sel_q  <= byte_sel_d;
      hdr_phase_q <= hdr_phase_d;
      last_sent_q <= last_sent_d;
      cur_word_q  <= cur_word_d;
`ifdef TRACE_CRC8_EN
      crc_q       <= crc_d;
      crc_phase_q <= crc_phase_d;
`endif
    end
  end

  // Reset-free so the array maps onto block RAM with a registered read port.
  always_ff @(posedge clk_27) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= probe_i;
    rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  uart_tx_byte #(
    .BIT_CYC (BIT_CYC)
  ) u_tx (
    .clk_27     (clk_27),
    .rst        (rst),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_byte),
    .tx_ready_o (tx_ready),
    .tx_o       (uart_tx_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_trace_uart_dump.sv
`default_nettype none
// ============================================================================
// tb_trace_uart_dump : scoreboard bench for trace_uart_dump (UART decoded by a line monitor)
// Rev 1.0            : initial release
// ============================================================================
module tb_trace_uart_dump;

  localparam int PW     = 54;
  localparam int DEPTH  = 4;
  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int BIT    = 10;
  localparam int NB     = 7;
  localparam int LIMIT  = 6000;

  logic          clk = 1'b0;
  logic          rst, sample_en, arm, trig;
  logic [PW-1:0] probe;
  logic          uart_tx, busy, done;
  logic          rst2, arm2, trig2;
  logic [PW-1:0] probe2;
  logic          sample_en2;
  logic          tx2, busy2, done2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_start = -1000000;
  int min_iv = 1 << 30;
  int max_iv = 0;
  int mon_iv;
  logic       mon_prev = 1'b1;
  logic [7:0] mon_d;
  logic [7:0] exp_q [$];
  logic [8:0] rx_q [$];

  trace_uart_dump #(.PROBE_W(PW), .DEPTH(DEPTH), .CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_27(clk), .rst(rst), .probe_i(probe), .sample_en_i(sample_en), .arm_i(arm),
    .trig_i(trig), .uart_tx_o(uart_tx), .busy_o(busy), .done_o(done));

  trace_uart_dump #(.PROBE_W(PW), .DEPTH(4)) dut_slow (
    .clk_27(clk), .rst(rst2), .probe_i(probe2), .sample_en_i(sample_en2), .arm_i(arm2),
    .trig_i(trig2), .uart_tx_o(tx2), .busy_o(busy2), .done_o(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Line monitor: decodes 8N1 frames and records start-to-start spacing of back-to-back bytes.
  always begin
    @(negedge clk);
    if (rst) begin
      mon_prev = 1'b1;
    end else if (mon_prev && uart_tx === 1'b0) begin
      mon_iv = cyc - last_start;
      last_start = cyc;
      if (mon_iv < 12 * BIT) begin
        if (mon_iv < min_iv) min_iv = mon_iv;
        if (mon_iv > max_iv) max_iv = mon_iv;
      end
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        mon_d[i] = uart_tx;
      end
      repeat (BIT) @(negedge clk);
      rx_q.push_back({uart_tx, mon_d});
      mon_prev = uart_tx;
    end else begin
      mon_prev = uart_tx;
    end
  end

  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  // Arms, triggers 3 clocks later and feeds DEPTH stored samples, queueing the expected frame.
  task automatic do_capture(input logic [PW-1:0] base, input bit stall, input bit constant);
    logic [55:0] w;
    int n, k;
`ifdef TRACE_CRC8_EN
    logic [7:0] crc;
    crc = 8'h00;
`endif
    exp_q.push_back(8'hA5);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (2) @(negedge clk);
    trig = 1'b1;
    n = 0;
    k = 0;
    while (n < DEPTH) begin
      probe     = constant ? base : base + PW'(k);
      sample_en = stall ? (k % 2 == 0) : 1'b1;
      if (sample_en) begin
        w = '0;
        w[PW-1:0] = probe;
        for (int b = 0; b < NB; b++) begin
          exp_q.push_back(w[8*b +: 8]);
`ifdef TRACE_CRC8_EN
          crc = crc8_ref(crc, w[8*b +: 8]);
`endif
        end
        n++;
      end
      @(negedge clk);
      trig = 1'b0;
      k++;
    end
`ifdef TRACE_CRC8_EN
    exp_q.push_back(crc);
`endif
    probe     = '1;
    sample_en = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
    @(negedge clk);
    sample_en = 1'b0;
    probe     = '0;
  endtask

  task automatic test_reset;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_idle_tx: got %b want 1", uart_tx); end
  endtask

  task automatic test_basic;
    bit ok;
    int d0, nexp;
    logic [7:0] e;
    logic [8:0] r;
    last_start = -1000000;
    min_iv = 1 << 30;
    max_iv = 0;
    d0 = done_cnt;
    do_capture(54'h10, 1'b0, 1'b0);
    nexp = exp_q.size();
    wait_done(ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout: done_o not seen within %0d clocks", LIMIT); end
    total++; if (rx_q.size() != nexp) begin bad++; $display("FAIL basic_len: got %0d bytes want %0d", rx_q.size(), nexp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      total++; if (r !== {1'b1, e}) begin bad++; $display("FAIL basic_byte: got %h want %h", r, {1'b1, e}); end
    end
    rx_q.delete();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    total++;
    if (min_iv < 10 * BIT || max_iv > 10 * BIT + 2) begin
      bad++;
      $display("FAIL basic_spacing: min %0d max %0d want %0d..%0d", min_iv, max_iv, 10 * BIT, 10 * BIT + 2);
    end
  endtask

  task automatic test_arm_trig_same;
    int errs;
    arm  = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    arm  = 1'b0;
    trig = 1'b0;
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b1 || uart_tx !== 1'b1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL armed_hold: %0d bad cycles, want 0", errs); end
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL armed_no_tx: got %0d bytes want 0", rx_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete();
  endtask

  task automatic test_stall;
    bit ok;
    int nexp;
    logic [7:0] e;
    logic [8:0] r;
    do_capture(54'h40, 1'b1, 1'b0);
    nexp = exp_q.size();
    wait_done(ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: done_o not seen within %0d clocks", LIMIT); end
    total++; if (rx_q.size() != nexp) begin bad++; $display("FAIL stall_len: got %0d bytes want %0d", rx_q.size(), nexp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      total++; if (r !== {1'b1, e}) begin bad++; $display("FAIL stall_byte: got %h want %h", r, {1'b1, e}); end
    end
    rx_q.delete();
  endtask

  task automatic test_arm_during_dump;
    bit ok;
    int nexp;
    logic [7:0] e;
    logic [8:0] r;
    do_capture(54'h80, 1'b0, 1'b0);
    nexp = exp_q.size();
    repeat (50) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (400) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    wait_done(ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL dumparm_timeout: done_o not seen within %0d clocks", LIMIT); end
    total++; if (rx_q.size() != nexp) begin bad++; $display("FAIL dumparm_len: got %0d bytes want %0d", rx_q.size(), nexp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      total++; if (r !== {1'b1, e}) begin bad++; $display("FAIL dumparm_byte: got %h want %h", r, {1'b1, e}); end
    end
    rx_q.delete();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dumparm_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_byte;
    bit ok;
    int n, nexp;
    logic [7:0] e;
    logic [8:0] r;
    do_capture(54'h200, 1'b0, 1'b0);
    n = 0;
    while (rx_q.size() < 3 && n < LIMIT) begin @(negedge clk); n++; end
    while (uart_tx !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    total++; if (n >= LIMIT) begin bad++; $display("FAIL rstmid_wait: no low bit within %0d clocks", LIMIT); end
    rst = 1'b1;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    exp_q.delete();
    rx_q.delete();
    do_capture(54'h300, 1'b0, 1'b0);
    nexp = exp_q.size();
    wait_done(ok);
    repeat (3) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: done_o not seen within %0d clocks", LIMIT); end
    total++; if (rx_q.size() != nexp) begin bad++; $display("FAIL rstmid_len: got %0d bytes want %0d", rx_q.size(), nexp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = 9'h000;
      if (rx_q.size() > 0) r = rx_q.pop_front();
      total++; if (r !== {1'b1, e}) begin bad++; $display("FAIL rstmid_byte: got %h want %h", r, {1'b1, e}); end
    end
    rx_q.delete();
  endtask

  task automatic test_constant_frames;
    bit ok;
    int nexp;
    logic [7:0] e;
    logic [8:0] r;
    for (int v = 0; v < 2; v++) begin
      do_capture(PW'(v), 1'b0, 1'b1);
      nexp = exp_q.size();
      wait_done(ok);
      repeat (3) @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL const%0d_timeout: done_o not seen within %0d clocks", v, LIMIT); end
      total++; if (rx_q.size() != nexp) begin bad++; $display("FAIL const%0d_len: got %0d bytes want %0d", v, rx_q.size(), nexp); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        r = 9'h000;
        if (rx_q.size() > 0) r = rx_q.pop_front();
        total++; if (r !== {1'b1, e}) begin bad++; $display("FAIL const%0d_byte: got %h want %h", v, r, {1'b1, e}); end
      end
      rx_q.delete();
    end
  endtask

  task automatic test_bit_period;
    int n, lo, hi;
    rst2 = 1'b0;
    @(negedge clk);
    arm2 = 1'b1;
    @(negedge clk);
    arm2  = 1'b0;
    trig2 = 1'b1;
    @(negedge clk);
    trig2 = 1'b0;
    n = 0;
    while (tx2 !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    lo = 0;
    while (tx2 === 1'b0 && lo < 1000) begin lo++; @(negedge clk); end
    hi = 0;
    while (tx2 === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
    total++; if (lo != 234) begin bad++; $display("FAIL bit_period_start: got %0d clocks want 234", lo); end
    total++; if (hi != 234) begin bad++; $display("FAIL bit_period_d0: got %0d clocks want 234", hi); end
    rst2 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; sample_en = 1'b0; probe = '0;
    rst2 = 1'b1; arm2 = 1'b0; trig2 = 1'b0; sample_en2 = 1'b1; probe2 = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_arm_trig_same;
    test_stall;
    test_arm_during_dump;
    test_reset_mid_byte;
    test_constant_frames;
    test_bit_period;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
